subservient_sram_bridge: RTL and testbench
==========================================

SUBSERVIENT_SRAM_BRIDGE -- requirements
Module: subservient_sram_bridge

Interface
REQ-001 Parameter AW, default 13: SoC byte-address width.
REQ-002 Parameter FLUSH_TIMEOUT, default 4: idle cycles before a partial buffered word is written to the macro.
REQ-003 The block SHALL have one clock, i_clk (input, 1), rising-edge.
REQ-004 Reset i_rst_n (input, 1) SHALL be asynchronous and active-low.
REQ-005 SoC side: i_waddr in AW, i_wdata in 8, i_wen in 1, i_raddr in AW, i_ren in 1, o_rdata out 8, i_flush in 1 (force write-back).
REQ-006 Macro side: o_csb0 out 1, o_wmask0 out 4, o_addr0 out 8, o_din0 out 32, o_csb1 out 1, o_addr1 out 8, i_dout1 in 32.
REQ-007 Status: o_pending out 1, high while the write buffer holds unwritten data.

Function
REQ-008 Word address SHALL be byte address bits [9:2]; lane SHALL be bits [1:0]; bits above 9 SHALL be ignored.
REQ-009 Write buffer: one entry of valid, 8-bit word address, 32-bit data, 4-bit mask, timeout counter.
REQ-010 i_wen with buffer empty: load address, write byte into its lane, set only that mask bit; counter cleared.
REQ-011 i_wen with buffer valid and same word, no flush this cycle: merge byte into lane, OR mask bit, clear counter; later byte to same lane overwrites.
REQ-012 Flush condition: valid AND (mask==4'hF OR counter==FLUSH_TIMEOUT OR i_flush OR (i_wen AND word differs)).
REQ-013 Flush cycle: o_csb0=0, o_addr0/o_wmask0/o_din0 from registered buffer; otherwise o_csb0=1.
REQ-014 Write arriving in a flush cycle SHALL load a fresh entry (mask = its lane only), even if same word; otherwise buffer clears after flush.
REQ-015 Counter increments each cycle valid and no i_wen, saturating at FLUSH_TIMEOUT.
REQ-016 Read: o_csb1 = ~i_ren, o_addr1 = i_raddr[9:2], combinational; lane and forward info registered on the i_ren edge.
REQ-017 o_rdata SHALL be valid exactly one cycle after i_ren; held until next i_ren.
REQ-018 Forwarding: if at the i_ren edge the pre-edge buffer is valid, same word, and mask bit of the lane set, o_rdata SHALL return buffered byte, else i_dout1 lane byte.
REQ-019 Same-cycle i_wen and i_ren to same byte: read returns prior value (buffer state before this write).
REQ-020 Read during flush cycle to flushed word SHALL be served by forwarding (macro same-address read/write collision never relied on).
REQ-021 o_pending = buffer valid.

Reset
REQ-022 On i_rst_n low: buffer valid=0, mask=0, counter=0, o_rdata=0, o_csb0=1, o_pending=0, forward/lane registers 0; o_csb1 follows i_ren.
REQ-023 Reset mid-coalesce SHALL discard buffered data without a macro write.

Configuration
REQ-024 Macro SRAM_WCOAL_EN defined: coalescing per REQ-010..015.
REQ-025 SRAM_WCOAL_EN undefined: every loaded entry flushes the following cycle unconditionally (effective FLUSH_TIMEOUT=0, no merging); forwarding per REQ-018 retained; interface unchanged.

Verification
REQ-026 Writes 0x11,0x22,0x33,0x44 to 0x100..0x103 on consecutive cycles -> single o_csb0=0 cycle next cycle, addr0=0x40, wmask0=4'hF, din0=0x44332211.
REQ-027 Write 0xAB to 0x205, idle -> flush after 4 idle cycles, addr0=0x81, wmask0=4'b0010, din0 lane1=0xAB; o_pending falls next cycle.
REQ-028 Write 0x5A to 0x010, read 0x010 next cycle -> o_rdata=0x5A one cycle later, macro dout ignored; read 0x011 -> macro byte returned.
REQ-029 Write 0x01 to 0x000 then 0x02 to 0x004 -> flush addr0=0x00 wmask0=4'b0001 in second cycle; new entry word 0x01 pending.
REQ-030 Write 0x77 to 0x008, assert i_rst_n low 1 cycle later -> o_csb0 never low, o_pending=0, o_rdata=0.
REQ-031 Build without SRAM_WCOAL_EN, same stimulus as REQ-026 -> four write cycles, wmask0 = 0001,0010,0100,1000, each one cycle after its write.

Source files
------------

// File: rtl/subservient_sram_bridge.sv
// subservient_sram_bridge: byte-wide SoC port to 32-bit dual-port SRAM macro with one-entry write coalescing.
// Define SRAM_WCOAL_EN to enable merging; otherwise every buffered byte is written the following cycle.
module subservient_sram_bridge #(
    parameter int AW            = 13,
    parameter int FLUSH_TIMEOUT = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_wen,
    input  logic [AW-1:0] i_raddr,
    input  logic          i_ren,
    output logic [7:0]    o_rdata,
    input  logic          i_flush,
    output logic          o_csb0,
    output logic [3:0]    o_wmask0,
    output logic [7:0]    o_addr0,
    output logic [31:0]   o_din0,
    output logic          o_csb1,
    output logic [7:0]    o_addr1,
    input  logic [31:0]   i_dout1,
    output logic          o_pending
);
    localparam int CW = $clog2(FLUSH_TIMEOUT + 2);

    logic        r_valid;
    logic [7:0]  r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_mask;
    logic        r_ract;
    logic        r_fwd;
    logic [7:0]  r_fbyte;
    logic [1:0]  r_lane;
    logic [7:0]  r_rdata;

    logic [7:0]  w_wword;
    logic [7:0]  w_rword;
    logic [3:0]  w_lmask;
    logic [31:0] w_bmask;
    logic        w_flush;
    logic        w_merge;
    logic [7:0]  w_rbyte;
    logic        w_unused;

    assign w_wword  = i_waddr[9:2];
    assign w_rword  = i_raddr[9:2];
    assign w_lmask  = 4'b0001 << i_waddr[1:0];
    assign w_bmask  = {{8{w_lmask[3]}}, {8{w_lmask[2]}}, {8{w_lmask[1]}}, {8{w_lmask[0]}}};
    assign w_merge  = i_wen && r_valid && !w_flush;
    assign w_rbyte  = r_fwd ? r_fbyte : i_dout1[{r_lane, 3'b000} +: 8];

`ifdef SRAM_WCOAL_EN
    logic [CW-1:0] r_cnt;
    assign w_unused = &{1'b0, i_waddr[AW-1:10], i_raddr[AW-1:10]};
    assign w_flush  = r_valid && (r_mask == 4'hF || r_cnt == CW'(FLUSH_TIMEOUT) || i_flush ||
                                  (i_wen && w_wword != r_addr));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_wen || w_flush) begin
            r_cnt <= '0;
        end else if (r_valid && r_cnt != CW'(FLUSH_TIMEOUT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_unused = &{1'b0, i_waddr[AW-1:10], i_raddr[AW-1:10], i_flush};
    assign w_flush  = r_valid;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_mask  <= '0;
        end else if (w_merge) begin
            r_data  <= (r_data & ~w_bmask) | ({4{i_wdata}} & w_bmask);
            r_mask  <= r_mask | w_lmask;
        end else if (i_wen) begin
            r_valid <= 1'b1;
            r_addr  <= w_wword;
            r_data  <= {4{i_wdata}};
            r_mask  <= w_lmask;
        end else if (w_flush) begin
            r_valid <= 1'b0;
            r_mask  <= '0;
        end
    end

    // Forward decision uses the buffer as it stood before this edge's write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ract  <= 1'b0;
            r_fwd   <= 1'b0;
            r_fbyte <= '0;
            r_lane  <= '0;
            r_rdata <= '0;
        end else begin
            r_ract <= i_ren;
            if (r_ract) r_rdata <= w_rbyte;
            if (i_ren) begin
                r_lane  <= i_raddr[1:0];
                r_fwd   <= r_valid && r_addr == w_rword && r_mask[i_raddr[1:0]];
                r_fbyte <= r_data[{i_raddr[1:0], 3'b000} +: 8];
            end
        end
    end

    assign o_rdata   = r_ract ? w_rbyte : r_rdata;
    assign o_csb0    = ~w_flush;
    assign o_addr0   = r_addr;
    assign o_wmask0  = r_mask;
    assign o_din0    = r_data;
    assign o_csb1    = ~i_ren;
    assign o_addr1   = w_rword;
    assign o_pending = r_valid;
endmodule

// File: tb/tb_subservient_sram_bridge.sv
// tb_subservient_sram_bridge: vector table, corner sequences and random coherency test against a byte-memory model.
module tb_subservient_sram_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] waddr, raddr;
    logic [7:0]  wdata;
    logic        wen, ren, flush;
    logic [7:0]  rdata;
    logic        csb0, csb1;
    logic [3:0]  wmask0;
    logic [7:0]  addr0, addr1;
    logic [31:0] din0;
    logic [31:0] dout1;
    logic        pending;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [256];
    logic [7:0]  gold [1024];
    logic        mon = 1'b0;
    logic        saw_low = 1'b0;

    always #5 clk = ~clk;

    subservient_sram_bridge #(.AW(13), .FLUSH_TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_waddr(waddr), .i_wdata(wdata), .i_wen(wen),
        .i_raddr(raddr), .i_ren(ren), .o_rdata(rdata), .i_flush(flush),
        .o_csb0(csb0), .o_wmask0(wmask0), .o_addr0(addr0), .o_din0(din0),
        .o_csb1(csb1), .o_addr1(addr1), .i_dout1(dout1), .o_pending(pending)
    );

    // Macro model: read returns the contents from before a same-edge write.
    always @(posedge clk) begin
        if (!csb0)
            for (int b = 0; b < 4; b++)
                if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
        if (!csb1) dout1 <= mem[addr1];
        if (mon && !csb0) saw_low <= 1'b1;
    end

    typedef struct {
        logic        wen;
        logic [12:0] waddr;
        logic [7:0]  wdata;
        logic        flush;
        logic        csb0;
        logic [7:0]  addr0;
        logic [3:0]  wmask0;
        logic [31:0] din0;
        logic        pend;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic logic [31:0] bm(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    task automatic idle_inputs();
        wen = 0; ren = 0; flush = 0; waddr = '0; wdata = '0; raddr = '0;
    endtask

    initial begin
        logic [7:0] exp_rd;
        logic       have_exp;
        logic [12:0] a;
        int         wait_n;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        dout1 = '0;
        rst_n = 0;
        idle_inputs();
        ren = 1;
        repeat (3) @(negedge clk);
        chk("reset csb0", csb0, 1);
        chk("reset pending", pending, 0);
        chk("reset rdata", rdata, 0);
        chk("reset csb1 follows ren", csb1, 0);
        ren = 0;
        #1 chk("reset csb1 idle", csb1, 1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

`ifdef SRAM_WCOAL_EN
        tbl.push_back('{1, 13'h100, 8'h11, 0, 1, 8'h00, 4'h0, 32'h0, 0});
        tbl.push_back('{1, 13'h101, 8'h22, 0, 1, 8'h00, 4'h0, 32'h0, 1});
        tbl.push_back('{1, 13'h102, 8'h33, 0, 1, 8'h00, 4'h0, 32'h0, 1});
        tbl.push_back('{1, 13'h103, 8'h44, 0, 1, 8'h00, 4'h0, 32'h0, 1});
        tbl.push_back('{0, 13'h000, 8'h00, 0, 0, 8'h40, 4'hF, 32'h44332211, 1});
        tbl.push_back('{0, 13'h000, 8'h00, 0, 1, 8'h00, 4'h0, 32'h0, 0});
        tbl.push_back('{1, 13'h205, 8'hAB, 0, 1, 8'h00, 4'h0, 32'h0, 0});
        for (int i = 0; i < 4; i++) tbl.push_back('{0, 13'h000, 8'h00, 0, 1, 8'h00, 4'h0, 32'h0, 1});
        tbl.push_back('{0, 13'h000, 8'h00, 0, 0, 8'h81, 4'h2, 32'h0000AB00, 1});
        tbl.push_back('{0, 13'h000, 8'h00, 0, 1, 8'h00, 4'h0, 32'h0, 0});
        tbl.push_back('{1, 13'h000, 8'h01, 0, 1, 8'h00, 4'h0, 32'h0, 0});
        tbl.push_back('{1, 13'h004, 8'h02, 0, 0, 8'h00, 4'h1, 32'h00000001, 1});
        tbl.push_back('{0, 13'h000, 8'h00, 0, 1, 8'h00, 4'h0, 32'h0, 1});
        tbl.push_back('{0, 13'h000, 8'h00, 1, 0, 8'h01, 4'h1, 32'h00000002, 1});
        tbl.push_back('{0, 13'h000, 8'h00, 0, 1, 8'h00, 4'h0, 32'h0, 0});
        tbl.push_back('{1, 13'h008, 8'h77, 0, 1, 8'h00, 4'h0, 32'h0, 0});
        tbl.push_back('{1, 13'h009, 8'h88, 1, 0, 8'h02, 4'h1, 32'h00000077, 1});
        tbl.push_back('{0, 13'h000, 8'h00, 1, 0, 8'h02, 4'h2, 32'h00008800, 1});
        tbl.push_back('{0, 13'h000, 8'h00, 0, 1, 8'h00, 4'h0, 32'h0, 0});
        tbl.push_back('{1, 13'h1C0C, 8'h10, 0, 1, 8'h00, 4'h0, 32'h0, 0});
        tbl.push_back('{1, 13'h00C, 8'h20, 0, 1, 8'h00, 4'h0, 32'h0, 1});
        tbl.push_back('{0, 13'h000, 8'h00, 1, 0, 8'h03, 4'h1, 32'h00000020, 1});
        tbl.push_back('{0, 13'h000, 8'h00, 0, 1, 8'h00, 4'h0, 32'h0, 0});
`else
        tbl.push_back('{1, 13'h100, 8'h11, 0, 1, 8'h00, 4'h0, 32'h0, 0});
        tbl.push_back('{1, 13'h101, 8'h22, 0, 0, 8'h40, 4'h1, 32'h00000011, 1});
        tbl.push_back('{1, 13'h102, 8'h33, 0, 0, 8'h40, 4'h2, 32'h00002200, 1});
        tbl.push_back('{1, 13'h103, 8'h44, 0, 0, 8'h40, 4'h4, 32'h00330000, 1});
        tbl.push_back('{0, 13'h000, 8'h00, 0, 0, 8'h40, 4'h8, 32'h44000000, 1});
        tbl.push_back('{0, 13'h000, 8'h00, 0, 1, 8'h00, 4'h0, 32'h0, 0});
        tbl.push_back('{1, 13'h1E05, 8'hAB, 0, 1, 8'h00, 4'h0, 32'h0, 0});
        tbl.push_back('{0, 13'h000, 8'h00, 0, 0, 8'h81, 4'h2, 32'h0000AB00, 1});
        tbl.push_back('{0, 13'h000, 8'h00, 0, 1, 8'h00, 4'h0, 32'h0, 0});
`endif
        foreach (tbl[i]) begin
            wen = tbl[i].wen; waddr = tbl[i].waddr; wdata = tbl[i].wdata; flush = tbl[i].flush;
            #1;
            chk($sformatf("vec%0d csb0", i), csb0, tbl[i].csb0);
            chk($sformatf("vec%0d pending", i), pending, tbl[i].pend);
            if (!tbl[i].csb0) begin
                chk($sformatf("vec%0d addr0", i), addr0, tbl[i].addr0);
                chk($sformatf("vec%0d wmask0", i), wmask0, tbl[i].wmask0);
                chk($sformatf("vec%0d din0", i), din0 & bm(wmask0), tbl[i].din0);
            end
            @(negedge clk);
        end
        idle_inputs();

        // Forwarding from the buffer, then a lane only the macro holds.
        mem[4] = 32'hDEADBEEF;
        mem[2] = 32'h12345678;
        @(negedge clk);
        wen = 1; waddr = 13'h010; wdata = 8'h5A;
        @(negedge clk);
        wen = 0; ren = 1; raddr = 13'h010;
        @(negedge clk);
        raddr = 13'h011;
        chk("fwd rdata", rdata, 8'h5A);
        @(negedge clk);
        ren = 0;
        chk("macro rdata", rdata, 8'hBE);
        @(negedge clk);
        chk("rdata hold", rdata, 8'hBE);
        flush = 1;
        @(negedge clk);
        flush = 0;
        @(negedge clk);
        chk("flushed pending", pending, 0);

        // Reset while a byte is buffered must drop it silently.
        mon = 1;
        wen = 1; waddr = 13'h008; wdata = 8'h77;
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        #1 chk("rst pending", pending, 0);
        chk("rst csb0", csb0, 1);
        chk("rst rdata", rdata, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (6) @(negedge clk);
        chk("rst no macro write", saw_low, 0);
        chk("rst mem intact", mem[2], 32'h12345678);
        chk("rst pending after", pending, 0);
        mon = 0;

        for (int i = 0; i < 1024; i++) gold[i] = mem[i >> 2][8*(i % 4) +: 8];
        have_exp = 0;
        exp_rd = '0;
        for (int c = 0; c < 3000; c++) begin
            bit sparse;
            sparse = ((c / 64) % 2) == 1;
            if (have_exp) chk("rand rdata", rdata, exp_rd);
            wen = sparse ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            a = $urandom;
            waddr = ($urandom_range(0, 7) == 0) ? a : {a[12:10], 10'($urandom_range(0, 31))};
            wdata = $urandom;
            ren = $urandom_range(0, 1) == 1;
            a = $urandom;
            raddr = ($urandom_range(0, 7) == 0) ? a : {a[12:10], 10'($urandom_range(0, 31))};
            flush = $urandom_range(0, 15) == 0;
            if (ren) begin
                exp_rd = gold[raddr[9:0]];
                have_exp = 1;
            end
            if (wen) gold[waddr[9:0]] = wdata;
            @(negedge clk);
        end
        if (have_exp) chk("rand rdata last", rdata, exp_rd);
        idle_inputs();
        flush = 1;
        @(negedge clk);
        flush = 0;
        wait_n = 0;
        while (pending && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        chk("drain pending", pending, 0);
        for (int w = 0; w < 256; w++)
            chk($sformatf("mem word %0d", w), mem[w], {gold[4*w+3], gold[4*w+2], gold[4*w+1], gold[4*w]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
